// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encryptor, UNROLL rounds per clock, valid/ready on both sides.
module aes128_iter_core #(
  parameter int UNROLL = 1,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [15:0]  blk_count
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Rcon indexed by round number; entry 0 and entries above 10 are unused padding.
  localparam logic [127:0] RCON = 128'h0001020408102040801b360000000000;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] subbytes(input logic [127:0] s);
    for (int i = 0; i < 16; i++) subbytes[8*i +: 8] = sb(s[8*i +: 8]);
  endfunction

  function automatic logic [127:0] shiftrow(input logic [127:0] s);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shiftrow[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mixcolumn(input logic [127:0] s);
    return {mixcol(s[127:96]), mixcol(s[95:64]), mixcol(s[63:32]), mixcol(s[31:0])};
  endfunction

  function automatic logic [127:0] key_generation(input logic [3:0] i, input logic [127:0] k);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sb(k[23:16]), sb(k[15:8]), sb(k[7:0]), sb(k[31:24])} ^ {RCON[{~i, 3'b111} -: 8], 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10) || (NR % UNROLL) != 0) begin : g_bad_unroll
      $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10 and divide NR");
    end
  endgenerate

  state_t st, st_nx;
  logic [127:0] s_q, k_q, s_nx, k_nx;
  logic [3:0] rnd;
  logic last;

  always_comb begin
    s_nx = s_q;
    k_nx = k_q;
    for (int j = 0; j < UNROLL; j++) begin
      k_nx = key_generation(rnd + 4'(j), k_nx);
      s_nx = shiftrow(subbytes(s_nx));
      s_nx = (int'(rnd) + j < NR) ? mixcolumn(s_nx) : s_nx;
      s_nx = s_nx ^ k_nx;
    end
  end

  assign last = int'(rnd) + UNROLL - 1 >= NR;

  always_ff @(posedge clk) st <= !rst_n ? IDLE : st_nx;

  always_comb
    st_nx = st == IDLE ? (in_valid ? ROUND : IDLE) :
            st == ROUND ? (last ? DONE : ROUND) :
            (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready  = st == IDLE;
    busy      = st != IDLE;
    out_valid = st == DONE;
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      s_q        <= '0;
      k_q        <= '0;
      rnd        <= '0;
      ciphertext <= '0;
      blk_count  <= '0;
    end else if (st == IDLE && in_valid) begin
      s_q <= plaintext ^ key;
      k_q <= key;
      rnd <= 4'd1;
    end else if (st == ROUND) begin
      s_q <= s_nx;
      k_q <= k_nx;
      rnd <= rnd + 4'(UNROLL);
      if (last) ciphertext <= s_nx;
    end else if (st == DONE && out_ready) begin
      blk_count <= blk_count + 16'd1;
    end
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: vector table plus random blocks against a byte-level AES model, on all four UNROLL builds.
module tb_aes128_iter_core;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int NV = 8;

  typedef struct {
    logic [127:0] pt, key, ct;
  } vec_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [127:0] pt = '0, key = '0;
  logic ir[4], ov[4], bz[4];
  logic [127:0] ct[4];
  logic [15:0] bc[4];
  logic [7:0] sbt[256];
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_core #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10), .NR(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]), .plaintext(pt), .key(key),
      .out_valid(ov[g]), .out_ready(out_ready), .ciphertext(ct[g]), .busy(bz[g]), .blk_count(bc[g]));
  end

  function automatic int ul(input int u);
    return u == 0 ? 1 : u == 1 ? 2 : u == 2 ? 5 : 10;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'(x);
      for (int k = 0; k < 253; k++) inv = gmul(inv, 8'(x));
      s = inv ^ 8'h63;
      for (int n = 1; n < 5; n++) s ^= 8'((inv << n) | (inv >> (8 - n)));
      sbt[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0] s[16], t[16], rc, acc;
    logic [127:0] r;
    int d;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbt[tmp[23:16]], sbt[tmp[15:8]], sbt[tmp[7:0]], sbt[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q+4*c] = sbt[s[q+4*((c+q)%4)]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) begin
          acc = 0;
          for (int m = 0; m < 4; m++) begin
            d = (m - q + 4) % 4;
            acc ^= gmul(d == 0 ? 8'h02 : d == 1 ? 8'h03 : 8'h01, t[m+4*c]);
          end
          s[q+4*c] = rn < 10 ? acc : t[q+4*c];
        end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*rn + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = s[b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[NV];
    int lat[4], n, idx, seen, cyc, tms[3];
    logic [127:0] got[4], outs[3], bpt[3], bkey[3], bexp[3];
    logic acc, spur;
    build_sbox();
    tv[0] = '{B_PT, B_KEY, B_CT};
    tv[1] = '{C_PT, C_KEY, C_CT};
    for (int v = 2; v < NV; v++) begin
      tv[v].pt  = rnd128();
      tv[v].key = rnd128();
      tv[v].ct  = aes_ref(tv[v].key, tv[v].pt);
    end

    tick();
    tick();
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_busy", bz[0], 0);
    chk("reset_ciphertext", ct[0], 0);
    chk("reset_blk_count", bc[0], 0);
    rst_n = 1;
    tick();

    // every vector on every UNROLL build; inputs are scrambled right after acceptance
    for (int v = 0; v < NV; v++) begin
      pt = tv[v].pt;
      key = tv[v].key;
      in_valid = 1;
      out_ready = 1;
      tick();
      in_valid = 0;
      pt = rnd128();
      key = rnd128();
      for (int u = 0; u < 4; u++) begin
        lat[u] = -1;
        got[u] = '0;
      end
      for (int c = 1; c <= 12; c++) begin
        tick();
        for (int u = 0; u < 4; u++)
          if (ov[u] && lat[u] < 0) begin
            lat[u] = c;
            got[u] = ct[u];
          end
      end
      for (int u = 0; u < 4; u++) begin
        chk($sformatf("vec%0d_u%0d_ct", v, ul(u)), got[u], tv[v].ct);
        chk($sformatf("vec%0d_u%0d_latency", v, ul(u)), lat[u], 10 / ul(u));
      end
      chk($sformatf("vec%0d_blk_count", v), bc[0], v + 1);
      chk($sformatf("vec%0d_in_ready", v), ir[0], 1);
    end

    // backpressure: output held for 20 cycles while in_valid pulses are ignored
    pt = B_PT;
    key = B_KEY;
    in_valid = 1;
    out_ready = 0;
    tick();
    in_valid = 0;
    n = 0;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    chk("bp_latency", n, 10);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      pt = rnd128();
      key = rnd128();
      tick();
      chk("bp_ct_stable", ct[0], B_CT);
      chk("bp_in_ready", ir[0], 0);
      chk("bp_out_valid", ov[0], 1);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_release_out_valid", ov[0], 0);
    chk("bp_release_in_ready", ir[0], 1);
    chk("bp_release_blk_count", bc[0], NV + 1);
    tick();
    chk("bp_no_stray_accept", ir[0], 1);

    // back-to-back: in_valid kept high across three blocks
    for (int i = 0; i < 3; i++) begin
      bpt[i] = rnd128();
      bkey[i] = rnd128();
      bexp[i] = aes_ref(bkey[i], bpt[i]);
      outs[i] = '0;
      tms[i] = 0;
    end
    idx = 0;
    seen = 0;
    cyc = 0;
    pt = bpt[0];
    key = bkey[0];
    in_valid = 1;
    while (seen < 3 && cyc < 80) begin
      acc = in_valid && ir[0];
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          pt = bpt[idx];
          key = bkey[idx];
        end else in_valid = 0;
      end
      if (ov[0]) begin
        outs[seen] = ct[0];
        tms[seen] = cyc;
        seen++;
      end
    end
    in_valid = 0;
    chk("b2b_count", seen, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_ct%0d", i), outs[i], bexp[i]);
    chk("b2b_spacing01", tms[1] - tms[0], 12);
    chk("b2b_spacing12", tms[2] - tms[1], 12);
    tick();
    chk("b2b_blk_count", bc[0], NV + 4);

    // reset with round 5 pending
    pt = B_PT;
    key = B_KEY;
    in_valid = 1;
    tick();
    in_valid = 0;
    for (int c = 0; c < 4; c++) tick();
    chk("mid_busy_before_reset", bz[0], 1);
    rst_n = 0;
    tick();
    chk("rst_out_valid", ov[0], 0);
    chk("rst_in_ready", ir[0], 1);
    chk("rst_blk_count", bc[0], 0);
    chk("rst_ciphertext", ct[0], 0);
    rst_n = 1;
    spur = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      spur |= ov[0];
    end
    chk("rst_no_spurious_output", spur, 0);
    pt = B_PT;
    key = B_KEY;
    in_valid = 1;
    tick();
    in_valid = 0;
    n = 0;
    while (!ov[0] && n < 20) begin
      tick();
      n++;
    end
    chk("post_rst_latency", n, 10);
    chk("post_rst_ct", ct[0], B_CT);
    tick();
    chk("post_rst_blk_count", bc[0], 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/aes128_iter_core.md
Name: aes128_iter_core

Overview:
- Iterative AES-128 encryption core with a valid/ready handshake on input and output.
- Built around the existing round datapath elements: subbytes, shiftrow, mixcolumn and KeyGeneration.
- Generalises the single combinational round to a full 10-round encryption, performed UNROLL rounds per clock, with the final round correctly omitting MixColumns.
- Sits between the block-data source and the ciphertext sink in the crypto top level.

Parameters:
- UNROLL, 1: rounds computed per clock. Legal values are 1, 2, 5 and 10. Any other value is a synthesis-time error, generated via an illegal generate branch.
- NR, 10: total AES rounds. Fixed at 10 for AES-128 and exposed only for the bench. NR must be divisible by UNROLL.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  plaintext/key pair presented.
- in_ready  out  1  core can accept a block; high only in IDLE.
- plaintext  in  128  input block; bit 127 is byte 0 (FIPS-197 order).
- key  in  128  cipher key, same byte order.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  sink accepts ciphertext.
- ciphertext  out  128  result, same byte order.
- busy  out  1  high in ROUND and DONE.
- blk_count  out  16  number of completed output handshakes; wraps from 0xFFFF to 0.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the core goes to IDLE. After that edge:
  - in_ready=1 (IDLE), out_valid=0, busy=0, ciphertext=0, blk_count=0.
  - Internal state register, round-key register and round counter are all 0.
  - Reset mid-ROUND or mid-DONE abandons the block with no output.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: state <= plaintext ^ key (initial AddRoundKey), rkey <= key, rnd <= 1, go to ROUND.
  - plaintext and key are sampled only on this edge; changes afterwards are ignored.
- ROUND:
  - Each cycle, apply UNROLL chained rounds with indices rnd .. rnd+UNROLL-1.
  - Round i computes: ks_i = KeyGeneration(i, ks_{i-1}); s = ShiftRows(SubBytes(s)); if i<NR then s = MixColumns(s); s = s ^ ks_i.
  - Register the final s and ks; rnd <= rnd + UNROLL.
  - When the last round applied is NR, register the result into ciphertext, set out_valid=1 and go to DONE.
  - Counter width is 4 bits. rnd never exceeds NR+1 and there is no wrap.
- Round index: the 4-bit index passed to KeyGeneration is the round number 1..10. KeyGeneration applies Rcon[i] internally.
- DONE:
  - out_valid=1; ciphertext held stable.
  - On out_ready=1: out_valid <= 0, blk_count <= blk_count+1, go to IDLE.
  - out_ready held low stalls the core indefinitely with the output stable.
- Latency: out_valid rises NR/UNROLL clocks after the accepting edge, i.e. 10/5/2/1 clocks for UNROLL=1/2/5/10.
- Throughput: one block per NR/UNROLL + 2 cycles with out_ready tied high.
- No input/output overlap: in_ready=0 during ROUND and DONE. The earliest new accept is the cycle after the output handshake.
- Simultaneous events: in_valid asserted while busy is ignored (no buffering). The source must hold in_valid until in_ready.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- FIPS-197 App. B, UNROLL=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1.
  - Expect ct 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 10 clocks after accept.
  - Expect blk_count=1.
- FIPS-197 App. C.1, all legal UNROLL values: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Expect ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expect latency 10/5/2/1 for UNROLL=1/2/5/10.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - Expect ciphertext stable, in_ready=0, and in_valid pulses ignored.
  - On release, expect one handshake and in_ready=1 on the next cycle.
- Back-to-back: keep in_valid high with 3 different blocks and out_ready=1.
  - Expect 3 correct ciphertexts in order, each 12 cycles apart (UNROLL=1).
  - Expect blk_count=3.
- Reset mid-operation: drive rst_n=0 at round 5.
  - Expect out_valid=0, in_ready=1 and blk_count=0 after the edge, with no spurious output.
  - Then a fresh App. B block must produce the correct ct.
- Input change after accept: alter plaintext and key during ROUND.
  - Expect ciphertext to match the values sampled at accept.
